// File: rtl/rr_mux4bit_arb.sv
// Round-robin arbiter feeding a one-entry output register.
// Two producer channels (A, B) compete for the register. The register holds
// the winning word together with its source. The source drives the
// downstream 2:1 mux select, so data and select always change together.
module rr_mux4bit_arb #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             a_valid,
    input  logic [WIDTH-1:0] a_data,
    output logic             a_ready,
    input  logic             b_valid,
    input  logic [WIDTH-1:0] b_data,
    output logic             b_ready,
    output logic             o_valid,
    output logic [WIDTH-1:0] o_data,
    input  logic             o_ready,
    output logic             sel,
    output logic             last_grant,
    output logic [CNT_W-1:0] xfer_count
);

    localparam logic SRC_A = 1'b0;
    localparam logic SRC_B = 1'b1;

    logic             o_valid_q, o_valid_d;
    logic [WIDTH-1:0] o_data_q, o_data_d;
    logic             sel_q, sel_d;
    logic             last_grant_q, last_grant_d;
    logic [CNT_W-1:0] xfer_count_q, xfer_count_d;

    logic             load_en;
    logic             grant_vld;
    logic             grant_src;
    logic             accept;

    // The register can take a new word when it is empty, or when its
    // current word leaves in this same cycle.
    assign load_en = !o_valid_q || o_ready;

    // Pick a source. On a tie, the source that was not granted last wins.
    always_comb begin
        grant_vld = 1'b0;
        grant_src = SRC_A;
        if (a_valid && b_valid) begin
            grant_vld = 1'b1;
            grant_src = ~last_grant_q;
        end else if (a_valid) begin
            grant_vld = 1'b1;
            grant_src = SRC_A;
        end else if (b_valid) begin
            grant_vld = 1'b1;
            grant_src = SRC_B;
        end
    end

    // The readys are forced low while reset is asserted. Otherwise an
    // empty register would appear ready during reset.
    assign accept  = !rst && load_en && grant_vld;
    assign a_ready = accept && (grant_src == SRC_A);
    assign b_ready = accept && (grant_src == SRC_B);

    // Next-state: load on accept, empty on drain, otherwise hold.
    // The pointer and the counter move only on an actual accept.
    always_comb begin
        o_valid_d    = o_valid_q;
        o_data_d     = o_data_q;
        sel_d        = sel_q;
        last_grant_d = last_grant_q;
        xfer_count_d = xfer_count_q;
        if (accept) begin
            o_valid_d    = 1'b1;
            o_data_d     = grant_src ? b_data : a_data;
            sel_d        = grant_src;
            last_grant_d = grant_src;
            xfer_count_d = xfer_count_q + CNT_W'(1);
        end else if (o_valid_q && o_ready) begin
            o_valid_d = 1'b0;
        end
    end

    // All state sits in async-reset flops, so a reset drops the held word
    // at once. The pointer resets to B, which lets A win the first tie.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            o_valid_q    <= 1'b0;
            o_data_q     <= '0;
            sel_q        <= SRC_A;
            last_grant_q <= SRC_B;
            xfer_count_q <= '0;
        end else begin
            o_valid_q    <= o_valid_d;
            o_data_q     <= o_data_d;
            sel_q        <= sel_d;
            last_grant_q <= last_grant_d;
            xfer_count_q <= xfer_count_d;
        end
    end

    assign o_valid    = o_valid_q;
    assign o_data     = o_data_q;
    assign sel        = sel_q;
    assign last_grant = last_grant_q;
    assign xfer_count = xfer_count_q;

endmodule

// File: tb/tb_rr_mux4bit_arb.sv
// Bench for rr_mux4bit_arb. A transaction-level model of the output slot
// predicts the DUT. The bench runs the directed scenarios first, then
// random traffic.
module tb_rr_mux4bit_arb;

    logic       clk;
    logic       rst;
    logic       a_valid, b_valid, o_ready;
    logic [3:0] a_data, b_data;
    logic       a_ready, b_ready, o_valid, sel, last_grant;
    logic [3:0] o_data;
    logic [7:0] xfer_count;

    int n_checks = 0;
    int n_pass   = 0;

    // Model: contents of the single output slot, and who was served last.
    bit       m_full;
    bit [3:0] m_word;
    bit       m_from_b;
    bit       m_last_b;
    bit [7:0] m_accepted;

    rr_mux4bit_arb #(.WIDTH(4), .CNT_W(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .a_valid    (a_valid),
        .a_data     (a_data),
        .a_ready    (a_ready),
        .b_valid    (b_valid),
        .b_data     (b_data),
        .b_ready    (b_ready),
        .o_valid    (o_valid),
        .o_data     (o_data),
        .o_ready    (o_ready),
        .sel        (sel),
        .last_grant (last_grant),
        .xfer_count (xfer_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    endtask

    task automatic model_reset();
        m_full     = 0;
        m_word     = 0;
        m_from_b   = 0;
        m_last_b   = 1;
        m_accepted = 0;
    endtask

    task automatic check_outputs();
        chk("o_valid", o_valid, m_full);
        chk("o_data", o_data, m_word);
        chk("sel", sel, m_from_b);
        chk("last_grant", last_grant, m_last_b);
        chk("xfer_count", xfer_count, m_accepted);
    endtask

    // One clock cycle. The task is entered at a negedge and returns at the
    // next negedge. The readys are checked mid-low-phase; the registered
    // outputs are checked just after the posedge.
    task automatic cycle(input bit av, input logic [3:0] ad,
                         input bit bv, input logic [3:0] bd, input bit ordy);
        bit slot_free, take, take_b;
        a_valid = av; a_data = ad;
        b_valid = bv; b_data = bd;
        o_ready = ordy;
        #2;
        // A word can enter only if the slot is empty or being emptied now.
        slot_free = !m_full || ordy;
        take      = slot_free && (av || bv);
        // On a tie, serve the channel that was not served last.
        if (av && bv) take_b = !m_last_b;
        else          take_b = bv;
        chk("a_ready", a_ready, take && !take_b);
        chk("b_ready", b_ready, take && take_b);
        @(posedge clk);
        #1;
        if (take) begin
            m_full     = 1;
            m_word     = take_b ? bd : ad;
            m_from_b   = take_b;
            m_last_b   = take_b;
            m_accepted = m_accepted + 8'd1;
        end else if (m_full && ordy) begin
            m_full = 0;
        end
        check_outputs();
        @(negedge clk);
    endtask

    task automatic do_reset();
        a_valid = 1; b_valid = 1; o_ready = 1;
        a_data = 4'hF; b_data = 4'hE;
        rst = 1;
        #2;
        chk("rst_a_ready", a_ready, 0);
        chk("rst_b_ready", b_ready, 0);
        @(negedge clk);
        @(negedge clk);
        rst = 0;
        model_reset();
        check_outputs();
        a_valid = 0; b_valid = 0;
    endtask

    initial begin
        rst = 1;
        a_valid = 0; b_valid = 0; o_ready = 0;
        a_data = 0; b_data = 0;
        model_reset();
        @(negedge clk);

        // Reset, then idle.
        do_reset();
        for (int i = 0; i < 5; i++) cycle(0, 4'h0, 0, 4'h0, 1);
        chk("idle_last_grant", last_grant, 1);

        // Single source.
        do_reset();
        for (int i = 0; i < 3; i++) cycle(1, 4'd5, 0, 4'h0, 1);
        chk("single_data", o_data, 5);
        chk("single_count", xfer_count, 3);

        // Contention alternation: 3, 12, 3, 12.
        do_reset();
        for (int i = 0; i < 4; i++) begin
            cycle(1, 4'd3, 1, 4'd12, 1);
            chk("alt_data", o_data, (i % 2 == 0) ? 3 : 12);
        end

        // Backpressure: load A=9, stall 3 cycles, then B wins.
        cycle(1, 4'd9, 1, 4'd12, 1);
        chk("bp_load", o_data, 9);
        for (int i = 0; i < 3; i++) cycle(1, 4'd1, 1, 4'd2, 0);
        chk("bp_hold_data", o_data, 9);
        chk("bp_hold_ptr", last_grant, 0);
        cycle(1, 4'd1, 1, 4'd2, 1);
        chk("bp_next_sel", sel, 1);

        // Counter wrap.
        do_reset();
        for (int i = 0; i < 256; i++) cycle(1, 4'(i), 0, 4'h0, 1);
        chk("wrap_zero", xfer_count, 0);
        cycle(1, 4'd4, 0, 4'h0, 1);
        chk("wrap_one", xfer_count, 1);

        // Reset mid-stream while holding 7.
        cycle(1, 4'd7, 0, 4'h0, 1);
        a_valid = 1; o_ready = 0;
        #2;
        rst = 1;
        #1;
        chk("mid_o_valid", o_valid, 0);
        chk("mid_o_data", o_data, 0);
        chk("mid_last_grant", last_grant, 1);
        chk("mid_a_ready", a_ready, 0);
        @(negedge clk);
        rst = 0;
        model_reset();
        cycle(1, 4'd6, 1, 4'd8, 1);
        chk("mid_tie_sel", sel, 0);

        // Random traffic.
        for (int i = 0; i < 400; i++)
            cycle($urandom_range(0, 1), 4'($urandom_range(0, 15)),
                  $urandom_range(0, 1), 4'($urandom_range(0, 15)),
                  ($urandom_range(0, 3) != 0));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/rr_mux4bit_arb.md
Name: rr_mux4bit_arb

Overview:
Upstream stage for the 4-bit 2:1 mux datapath. Arbitrates between two 4-bit producer channels (A, B) with round-robin fairness. Holds the winner in a one-entry output register with valid/ready handshake. Drives the mux select with the source of the held word, so the downstream mux and its consumer see a stable A/B/S triple per transfer.

Parameters:
WIDTH, 4, data width of each channel and of o_data.
CNT_W, 8, width of the wrapping accepted-transfer counter.

Ports:
clk  input  1  rising-edge clock.
rst  input  1  asynchronous active-high reset.
a_valid  input  1  channel A has a word.
a_data  input  WIDTH  channel A word.
a_ready  output  1  channel A word accepted this cycle.
b_valid  input  1  channel B has a word.
b_data  input  WIDTH  channel B word.
b_ready  output  1  channel B word accepted this cycle.
o_valid  output  1  output register holds a word.
o_data  output  WIDTH  held word.
o_ready  input  1  downstream consumes the held word this cycle.
sel  output  1  source of the held word (0=A, 1=B); drives the mux S input.
last_grant  output  1  round-robin pointer, the last source granted.
xfer_count  output  CNT_W  number of words accepted from A or B, wrapping.

Behaviour:
- Reset (async, active-high, asynchronous assert): o_valid=0, o_data=0, sel=0, last_grant=1 (so A wins the first tie), xfer_count=0. a_ready=0 and b_ready=0 while rst is high.
- load_en = !o_valid || o_ready (combinational). The register is either empty, or drained in the same cycle it is refilled.
- Grant (combinational):
  - If a_valid and b_valid, grant the source != last_grant.
  - If only one is valid, grant that one.
  - If none is valid, no grant.
- a_ready = load_en && grant==A. b_ready = load_en && grant==B. At most one ready is high per cycle.
- The ready outputs depend combinationally on o_ready and the valid inputs. No input depends combinationally on any ready output.
- Transfer on accept, next edge:
  - o_data <= granted data, sel <= granted source, o_valid <= 1.
  - last_grant <= granted source.
  - xfer_count <= xfer_count+1, wrapping to 0 after all ones.
- Drain without accept (o_valid && o_ready, no grant): o_valid <= 0. o_data and sel hold their last values.
- Hold (o_valid && !o_ready):
  - o_data, sel and o_valid are stable.
  - Both readys are 0, and the inputs are not sampled.
  - last_grant does not move.
- Throughput: one word per cycle when o_ready is held high. Latency from accept to o_valid is 1 cycle.
- Fairness: with both channels continuously valid and o_ready=1, the output strictly alternates A,B,A,B starting with A after reset.
- The pointer only advances on an actual accept. A contested-but-stalled cycle does not change priority.
- Reset mid-operation: the held word is discarded immediately (o_valid drops asynchronously) and the pointer returns to 1. There is no partial transfer, since all state is in the async-reset flops.

Test Plan:
- Reset then idle: rst pulse, a_valid=b_valid=0 for 5 cycles -> o_valid=0, o_data=0, sel=0, last_grant=1, xfer_count=0 throughout.
- Single source: a_valid=1, a_data=5, o_ready=1 for 3 cycles -> a_ready=1 each cycle; o_valid=1 from cycle 1 with o_data=5, sel=0; xfer_count=3.
- Contention alternation: a_data=3, b_data=12, both valid, o_ready=1 for 4 cycles -> output sequence 3(sel0), 12(sel1), 3(sel0), 12(sel1); readys alternate starting with a_ready.
- Backpressure: load A=9, then o_ready=0 for 3 cycles with both valid -> o_data=9, sel=0 stable; a_ready=b_ready=0; last_grant stays 0. Raise o_ready -> B is granted next.
- Counter wrap: CNT_W=8, 256 accepted words -> xfer_count returns to 0. One more accepted word -> xfer_count=1.
- Reset mid-stream: assert rst between clock edges while o_valid=1, o_data=7 -> o_valid=0, o_data=0, last_grant=1 before the next edge. After release, a tie grants A first.
